// File: rtl/generate_clock_divider.sv
// Three independent counter-based dividers producing 10 kHz, 50 kHz and ~38 kHz
// square waves from the 50 MHz system clock; each output comes straight from a flop.

module generate_clock_divider_channel #(
  parameter int unsigned HALF  = 2,
  parameter int unsigned CNT_W = 1
) (
  input  logic clk_in,
  input  logic rst_n,
  output logic q
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values of the others; the async reset clears both cnt and q.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (cnt == LAST) begin
      cnt <= '0;
      q   <= ~q;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

module generate_clock_divider #(
  parameter int unsigned HALF_10K = 2500,
  parameter int unsigned HALF_50K = 500,
  parameter int unsigned HALF_38K = 658
) (
  input  logic clk_in,
  output logic clk_10k,
  output logic clk_50k,
  output logic clk_38k,
  input  logic rst_n
);

  // Nominal widths are 12/9/10 bits; grow them if a parameter override needs more.
  function automatic int unsigned cnt_width(input int unsigned half,
                                            input int unsigned nominal);
    int unsigned need;
    need = (half > 1) ? $clog2(half) : 1;
    return (need > nominal) ? need : nominal;
  endfunction

  localparam int unsigned W_10K = cnt_width(HALF_10K, 12);
  localparam int unsigned W_50K = cnt_width(HALF_50K, 9);
  localparam int unsigned W_38K = cnt_width(HALF_38K, 10);

  generate_clock_divider_channel #(
    .HALF  (HALF_10K),
    .CNT_W (W_10K)
  ) u_ch_10k (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .q      (clk_10k)
  );

  generate_clock_divider_channel #(
    .HALF  (HALF_50K),
    .CNT_W (W_50K)
  ) u_ch_50k (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .q      (clk_50k)
  );

  generate_clock_divider_channel #(
    .HALF  (HALF_38K),
    .CNT_W (W_38K)
  ) u_ch_38k (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .q      (clk_38k)
  );

endmodule

// File: tb/tb_generate_clock_divider.sv
// Scoreboard bench: expected toggle events (channel, edge, level) are queued when
// reset is released and popped as each DUT output transition is observed.

module tb_generate_clock_divider;

  localparam int RUN  = 20000;
  localparam int MID  = 3000;
  localparam int POST = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic d10, d50, d38;
  logic o10, o50, o38;

  always #10 clk = ~clk;

  generate_clock_divider u_dut (
    .clk_in  (clk),
    .clk_10k (d10),
    .clk_50k (d50),
    .clk_38k (d38),
    .rst_n   (rst_n)
  );

  generate_clock_divider #(
    .HALF_50K (1),
    .HALF_38K (3)
  ) u_ovr (
    .clk_in  (clk),
    .clk_10k (o10),
    .clk_50k (o50),
    .clk_38k (o38),
    .rst_n   (rst_n)
  );

  typedef struct {
    int   ch;
    int   edge_n;
    logic level;
  } ev_t;

  ev_t  sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   edge_n;
  logic [5:0] prev;
  int   toggles [6];
  int   half    [6] = '{2500, 500, 658, 2500, 1, 3};
  int   exp_tog [6] = '{8, 40, 30, 8, 20000, 6666};

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    n_cmp++;
    if (observed !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [5:0] outs();
    return {o38, o50, o10, d38, d50, d10};
  endfunction

  task automatic push_expected(input int n);
    logic [5:0] lvl;
    ev_t ev;
    lvl = '0;
    for (int e = 1; e <= n; e++) begin
      for (int ch = 0; ch < 6; ch++) begin
        if (e % half[ch] == 0) begin
          lvl[ch]   = ~lvl[ch];
          ev.ch     = ch;
          ev.edge_n = e;
          ev.level  = lvl[ch];
          sb.push_back(ev);
        end
      end
    end
  endtask

  task automatic release_reset(input int n);
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
    prev   = '0;
    for (int ch = 0; ch < 6; ch++) toggles[ch] = 0;
    push_expected(n);
  endtask

  task automatic run_edges(input int n);
    logic [5:0] cur;
    ev_t ev;
    repeat (n) begin
      @(posedge clk);
      edge_n++;
      #1;
      cur = outs();
      for (int ch = 0; ch < 6; ch++) begin
        if (cur[ch] !== prev[ch]) begin
          toggles[ch]++;
          if (sb.size() == 0) begin
            check($sformatf("sb_underflow_ch%0d_e%0d", ch, edge_n), sb.size(), 1);
          end else begin
            ev = sb.pop_front();
            check($sformatf("toggle_ch_e%0d", edge_n), ch, ev.ch);
            check($sformatf("toggle_edge_ch%0d", ch), edge_n, ev.edge_n);
            check($sformatf("toggle_level_ch%0d_e%0d", ch, edge_n), cur[ch], ev.level);
          end
        end
      end
      prev = cur;
    end
  endtask

  task automatic check_all_low(input string tag);
    logic [5:0] cur;
    cur = outs();
    for (int ch = 0; ch < 6; ch++)
      check($sformatf("%s_out_ch%0d", tag, ch), cur[ch], 1'b0);
  endtask

  initial begin
    // Reset held with clock running
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_all_low("reset");
    check("reset_cnt_10k", u_dut.u_ch_10k.cnt, 0);
    check("reset_cnt_50k", u_dut.u_ch_50k.cnt, 0);
    check("reset_cnt_38k", u_dut.u_ch_38k.cnt, 0);

    // Main run: all toggles scored against the queued model
    release_reset(RUN);
    run_edges(RUN);
    check("main_sb_left", sb.size(), 0);
    for (int ch = 0; ch < 6; ch++)
      check($sformatf("main_toggles_ch%0d", ch), toggles[ch], exp_tog[ch]);

    // Mid-operation asynchronous reset, 5 ns after edge MID
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    release_reset(MID);
    run_edges(MID);
    check("mid_sb_left", sb.size(), 0);
    check("mid_pre_10k_high", d10, 1'b1);
    #4;
    rst_n = 1'b0;
    #1;
    check_all_low("async_reset");
    repeat (3) @(posedge clk);

    // Restart after release: latencies begin again from edge 0
    release_reset(POST);
    run_edges(POST);
    check("post_sb_left", sb.size(), 0);
    check("post_toggles_50k", toggles[1], 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
